fir_mul_arbiter: RTL and testbench



---
 rtl/fir_mul_arbiter_if.sv | 27 ++
 rtl/fir_mul_arbiter.sv | 157 +++++++++++++++
 tb/tb_fir_mul_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fir_mul_arbiter_if.sv
// Bundle of requester, grant and result signals for the shared FIR multiplier.
// The master side is the filter bank; the slave side is the arbiter.
interface fir_mul_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_W       = 3
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*DATA_WIDTH-1:0] a_in;
  logic [NUM_REQ*DATA_WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]            gnt;
  logic [DATA_WIDTH-1:0]         result;
  logic [ID_W-1:0]               result_id;
  logic                          result_valid;
  logic                          result_ready;

  modport master (
    output req, lock, a_in, b_in, result_ready,
    input  gnt, result, result_id, result_valid
  );

  modport slave (
    input  req, lock, a_in, b_in, result_ready,
    output gnt, result, result_id, result_valid
  );
endinterface

// File: rtl/fir_mul_arbiter.sv
// Round-robin arbiter with optional per-sweep lock, sharing one 2-stage Q-format
// signed multiplier between FIR requesters. Define FIR_MUL_SATURATE_EN to saturate.
module fir_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int ID_W       = 3
) (
  input  logic             clock,
  input  logic             reset,
  fir_mul_arbiter_if.slave bus
);

  typedef enum logic {MODE_RR, MODE_LOCKED} mode_t;

  mode_t                   mode_q, mode_d;
  logic [ID_W-1:0]         owner_q, owner_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;

  logic                    stall;
  logic                    xfer;
  logic                    lock_sel;
  logic [NUM_REQ-1:0]      gnt;
  logic [ID_W-1:0]         gnt_idx;
  logic [DATA_WIDTH-1:0]   sel_a, sel_b;

  logic                    s1_valid;
  logic signed [DATA_WIDTH-1:0] s1_a, s1_b;
  logic [ID_W-1:0]         s1_id;
  logic                    s2_valid;
  logic [DATA_WIDTH-1:0]   s2_result;
  logic [ID_W-1:0]         s2_id;

  logic signed [2*DATA_WIDTH-1:0] prod, shifted;
  logic [DATA_WIDTH-1:0]          scaled;

  assign stall = s2_valid & ~bus.result_ready;

  // Grant: locked owner wins outright; otherwise nearest requester at or after ptr.
  always_comb begin
    int best_d;
    int d;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt     = '0;
    gnt_idx = '0;
    best_d  = NUM_REQ;
    d       = 0;
    if (!reset && !stall) begin
      if (mode_q == MODE_LOCKED) begin
        for (int i = 0; i < NUM_REQ; i++) gnt[i] = (ID_W'(i) == owner_q);
        gnt_idx = owner_q;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          d = (i + NUM_REQ - int'(ptr_q)) % NUM_REQ;
          if (bus.req[i] && d < best_d) begin
            best_d  = d;
            gnt_idx = ID_W'(i);
          end
        end
        if (best_d < NUM_REQ) begin
          for (int i = 0; i < NUM_REQ; i++) gnt[i] = (ID_W'(i) == gnt_idx);
        end
      end
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    lock_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a    = bus.a_in[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b    = bus.b_in[i*DATA_WIDTH +: DATA_WIDTH];
        lock_sel = bus.lock[i];
      end
    end
  end

  assign xfer = |(bus.req & gnt);

  always_comb begin
    mode_d  = mode_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      if (lock_sel) begin
        mode_d  = MODE_LOCKED;
        owner_d = gnt_idx;
      end else begin
        mode_d = MODE_RR;
        ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_RR;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      mode_q  <= mode_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign prod    = (2*DATA_WIDTH)'(s1_a) * (2*DATA_WIDTH)'(s1_b);
  assign shifted = prod >>> FRAC_BITS;

`ifdef FIR_MUL_SATURATE_EN
  // In range only when every bit above the result sign bit matches it.
  always_comb begin
    if (&shifted[2*DATA_WIDTH-1:DATA_WIDTH-1] || ~|shifted[2*DATA_WIDTH-1:DATA_WIDTH-1])
      scaled = shifted[DATA_WIDTH-1:0];
    else if (shifted[2*DATA_WIDTH-1])
      scaled = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      scaled = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  assign scaled = DATA_WIDTH'(shifted);
`endif

  // Both stages freeze together while the consumer back-pressures.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_id     <= '0;
    end else if (!stall) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_id <= gnt_idx;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= scaled;
        s2_id     <= s1_id;
      end
    end
  end

  assign bus.gnt          = gnt;
  assign bus.result       = s2_result;
  assign bus.result_id    = s2_id;
  assign bus.result_valid = s2_valid;

endmodule

// File: tb/tb_fir_mul_arbiter.sv
// Directed bench for fir_mul_arbiter: reset, Q10 arithmetic, round-robin order,
// lock hold/release, back-pressure and mid-flight reset.
module tb_fir_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int FB      = 10;
  localparam int ID_W    = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int bp_rdy   [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int bp_gnt   [10] = '{2, 2, 0, 0, 0, 2, 2, 0, 0, 0};
  int bp_valid [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  int bp_res   [10] = '{0, 0, 1, 1, 1, 1, 2, 3, 4, 0};

  always #5 clock = ~clock;

  fir_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ID_W(ID_W)) bus ();

  fir_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .FRAC_BITS(FB), .ID_W(ID_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.a_in[idx*DW +: DW] = a;
    bus.b_in[idx*DW +: DW] = b;
  endtask

  // One isolated transfer from requester idx, checked through its 2-cycle latency.
  task automatic do_single(input string tag, input int idx, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] exp);
    logic [NUM_REQ-1:0] one_hot;
    one_hot      = '0;
    one_hot[idx] = 1'b1;
    bus.req      = one_hot;
    bus.lock     = '0;
    set_ops(idx, a, b);
    #1;
    check({tag, "_gnt"}, 64'(bus.gnt), 64'(one_hot));
    tick();
    bus.req = '0;
    check({tag, "_lat1"}, 64'(bus.result_valid), 64'(0));
    tick();
    check({tag, "_valid"}, 64'(bus.result_valid), 64'(1));
    check({tag, "_result"}, 64'(bus.result), 64'(exp));
    check({tag, "_id"}, 64'(bus.result_id), 64'(idx));
    tick();
    check({tag, "_done"}, 64'(bus.result_valid), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] ovf_exp;
    int            sent;

    bus.req          = '0;
    bus.lock         = '0;
    bus.a_in         = '0;
    bus.b_in         = '0;
    bus.result_ready = 1'b1;
    #1;
    check("rst_gnt", 64'(bus.gnt), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_id", 64'(bus.result_id), 64'(0));
    check("rst_valid", 64'(bus.result_valid), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Q10 arithmetic
    do_single("unit", 0, 32'h0000_0400, 32'h0000_0400, 32'h0000_0400);
    do_single("neg", 0, 32'hFFFF_FC00, 32'h0000_0800, 32'hFFFF_F800);
    do_single("small", 0, 32'h0000_0009, 32'h0000_0064, 32'h0000_0000);
`ifdef FIR_MUL_SATURATE_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = 32'hFFC0_0000;
`endif
    do_single("ovf", 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, ovf_exp);
    // Transfer from 3 wraps the pointer back to 0.
    do_single("req3", 3, 32'h0000_0800, 32'h0000_0200, 32'h0000_0400);

    // Round robin with all requesters active
    bus.req = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, DW'((i + 1) << 10), 32'h0000_0400);
    for (int k = 0; k < 10; k++) begin
      if (k == 8) bus.req = '0;
      #1;
      if (k < 8) check("rr_gnt", 64'(bus.gnt), 64'(1 << (k % 4)));
      if (k >= 2) begin
        check("rr_valid", 64'(bus.result_valid), 64'(1));
        check("rr_id", 64'(bus.result_id), 64'((k - 2) % 4));
        check("rr_result", 64'(bus.result), 64'(((k - 2) % 4 + 1) << 10));
      end
      tick();
    end
    check("rr_drain", 64'(bus.result_valid), 64'(0));

    // Lock: pointer to 2 first, then requester 2 holds the multiplier for 20 transfers
    do_single("pre_lock", 1, 32'h0000_0400, 32'h0000_0400, 32'h0000_0400);
    bus.req = 4'hF;
    set_ops(2, 32'h0000_0400, 32'h0000_0400);
    for (int k = 0; k < 23; k++) begin
      if (k < 20) begin
        bus.lock = (k < 19) ? 4'b0100 : 4'b0000;
        bus.b_in[2*DW +: DW] = DW'((k + 1) << 10);
      end
      #1;
      if (k < 20) check("lock_gnt", 64'(bus.gnt), 64'(4));
      if (k == 20) begin
        check("unlock_gnt", 64'(bus.gnt), 64'(8));
        bus.req  = '0;
        bus.lock = '0;
      end
      if (k >= 2 && k < 22) begin
        check("lock_valid", 64'(bus.result_valid), 64'(1));
        check("lock_id", 64'(bus.result_id), 64'(2));
        check("lock_result", 64'(bus.result), 64'((k - 1) << 10));
      end
      if (k == 22) check("lock_drain", 64'(bus.result_valid), 64'(0));
      tick();
    end

    // Back-pressure on a stream from requester 1
    sent = 0;
    bus.a_in[1*DW +: DW] = 32'h0000_0400;
    for (int c = 0; c < 10; c++) begin
      bus.result_ready = bp_rdy[c][0];
      bus.req          = (sent < 4) ? 4'b0010 : 4'b0000;
      bus.b_in[1*DW +: DW] = DW'((sent + 1) << 10);
      #1;
      check("bp_gnt", 64'(bus.gnt), 64'(bp_gnt[c]));
      check("bp_valid", 64'(bus.result_valid), 64'(bp_valid[c]));
      if (bp_valid[c] != 0) begin
        check("bp_result", 64'(bus.result), 64'(bp_res[c] << 10));
        check("bp_id", 64'(bus.result_id), 64'(1));
      end
      if (bp_gnt[c] != 0) sent++;
      tick();
    end
    bus.result_ready = 1'b1;

    // Reset with two products in flight
    bus.req  = 4'hF;
    bus.lock = '0;
    set_ops(0, 32'h0000_0400, 32'h0000_0400);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_gnt", 64'(bus.gnt), 64'(0));
    check("mid_rst_valid", 64'(bus.result_valid), 64'(0));
    check("mid_rst_result", 64'(bus.result), 64'(0));
    check("mid_rst_id", 64'(bus.result_id), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_gnt", 64'(bus.gnt), 64'(1));
    check("post_rst_valid0", 64'(bus.result_valid), 64'(0));
    tick();
    check("post_rst_valid1", 64'(bus.result_valid), 64'(0));
    bus.req = '0;
    tick();
    check("post_rst_valid2", 64'(bus.result_valid), 64'(1));
    check("post_rst_id", 64'(bus.result_id), 64'(0));
    check("post_rst_result", 64'(bus.result), 64'(32'h0000_0400));
    tick();
    check("post_rst_drain", 64'(bus.result_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
